secded_decode_arbiter: RTL and testbench

- Shares one SECDED (8,4) Hamming decode datapath between two requesters.
- Each requester presents 8-bit codewords. The block arbitrates round-robin, decodes the winner, and holds the result in a registered output stage with valid/ready backpressure.
- It also keeps saturating counts of corrected and uncorrectable (double) errors for status readout.
- It sits between the link/memory receive side and the 4-bit data consumers.

---
 rtl/secded_decode_arbiter.sv | 224 ++++++++++++++++++++++
 tb/tb_secded_decode_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/secded_decode_arbiter.sv
// ---------------------------------------------------------------------------
// secded_decode_arbiter
//
// Two requesters share one SECDED (8,4) extended-Hamming decoder. A
// round-robin arbiter picks one valid codeword per cycle. The decoded result
// is held in a registered output stage with valid/ready handshaking.
// Saturating counters track corrected and uncorrectable words.
//
// Ports
//   clk       : clock, all state changes on the rising edge
//   reset     : synchronous, active-high reset
//   in_valid  : [1:0] per-requester codeword present
//   in_code   : [15:0] requester i codeword at [8i+7:8i]
//               (bit 7 = overall parity, bits 6:0 = Hamming(7,4))
//   in_ready  : [1:0] per-requester accept strobe (combinational)
//   out_valid : decoded result held
//   out_ready : consumer takes the held result
//   out_src   : requester index of the held result
//   out_data  : [3:0] decoded data nibble
//   out_code  : [7:0] corrected codeword (raw codeword on double error)
//   out_corr  : single error corrected (parity bit 7 included)
//   out_derr  : double error detected, not correctable
//   clr_cnt   : synchronous clear of both error counters
//   corr_cnt  : [CNT_W-1:0] saturating count of corrected words accepted
//   derr_cnt  : [CNT_W-1:0] saturating count of double-error words accepted
// ---------------------------------------------------------------------------
module secded_decode_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       in_valid,
  input  logic [15:0]      in_code,
  output logic [1:0]       in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_src,
  output logic [3:0]       out_data,
  output logic [7:0]       out_code,
  output logic             out_corr,
  output logic             out_derr,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] derr_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  typedef struct packed {
    logic       derr;
    logic       corr;
    logic [7:0] code;
    logic [3:0] data;
  } dec_t;

  // Hamming(7,4) syndrome. Codeword bit position k (1..7) lives in c[k-1],
  // so a non-zero syndrome names the failing bit position directly.
  function automatic logic [2:0] hamming_syndrome(input logic [7:0] c);
    logic [2:0] s;
    s[0] = c[0] ^ c[2] ^ c[4] ^ c[6];
    s[1] = c[1] ^ c[2] ^ c[5] ^ c[6];
    s[2] = c[3] ^ c[4] ^ c[5] ^ c[6];
    return s;
  endfunction

  // Even overall parity across all eight bits; 1 means an odd number of flips.
  function automatic logic overall_parity(input logic [7:0] c);
    return ^c;
  endfunction

  // Full SECDED classification and correction of one codeword.
  function automatic dec_t secded_decode(input logic [7:0] c);
    dec_t       d;
    logic [2:0] s;
    logic       p;
    s      = hamming_syndrome(c);
    p      = overall_parity(c);
    d.code = c;
    d.corr = 1'b0;
    d.derr = 1'b0;
    case ({(s != 3'd0), p})
      2'b00: begin
        d.code = c;
      end
      2'b01: begin
        // Syndrome clean but parity odd: only the overall parity bit flipped.
        d.code = c ^ 8'h80;
        d.corr = 1'b1;
      end
      2'b11: begin
        d.code = c ^ (8'h01 << (s - 3'd1));
        d.corr = 1'b1;
      end
      2'b10: begin
        // Even parity with a non-zero syndrome can only be two flips.
        d.derr = 1'b1;
      end
      default: begin
        d.code = c;
      end
    endcase
    d.data = {d.code[6], d.code[5], d.code[4], d.code[2]};
    return d;
  endfunction

  logic             r_out_valid;
  logic             r_out_src;
  logic [3:0]       r_out_data;
  logic [7:0]       r_out_code;
  logic             r_out_corr;
  logic             r_out_derr;
  logic             r_last;
  logic [CNT_W-1:0] r_corr_cnt;
  logic [CNT_W-1:0] r_derr_cnt;

  logic             w_gnt;
  logic             w_slot_free;
  logic             w_accept;
  logic [7:0]       w_sel_code;
  dec_t             w_dec;

  // Round-robin grant: a lone requester always wins; on contention the
  // requester that did not win last time goes next.
  always_comb begin
    w_gnt = 1'b0;
    case (in_valid)
      2'b01:   w_gnt = 1'b0;
      2'b10:   w_gnt = 1'b1;
      2'b11:   w_gnt = ~r_last;
      default: w_gnt = 1'b0;
    endcase
  end

  assign w_slot_free = ~r_out_valid | out_ready;
  // Whenever any request is present the granted requester is valid, so the
  // accept needs only the OR of in_valid.
  assign w_accept    = (|in_valid) & w_slot_free & ~reset;
  assign w_sel_code  = w_gnt ? in_code[15:8] : in_code[7:0];
  assign w_dec       = secded_decode(w_sel_code);

  // Accept strobe routed back to the granted requester only.
  always_comb begin
    in_ready = 2'b00;
    if (w_accept) begin
      if (w_gnt) begin
        in_ready = 2'b10;
      end else begin
        in_ready = 2'b01;
      end
    end else begin
      in_ready = 2'b00;
    end
  end

  // Output holding stage: load on accept, drop valid on a drain-only cycle,
  // otherwise hold every field.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_src   <= 1'b0;
      r_out_data  <= 4'h0;
      r_out_code  <= 8'h00;
      r_out_corr  <= 1'b0;
      r_out_derr  <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_src   <= w_gnt;
      r_out_data  <= w_dec.data;
      r_out_code  <= w_dec.code;
      r_out_corr  <= w_dec.corr;
      r_out_derr  <= w_dec.derr;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  // Last-grant pointer; starts at 1 so requester 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= 1'b1;
    end else if (w_accept) begin
      r_last <= w_gnt;
    end else begin
      r_last <= r_last;
    end
  end

  // Corrected-word counter: clear wins over a same-cycle increment, and the
  // count sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset || clr_cnt) begin
      r_corr_cnt <= CNT_ZERO;
    end else if (w_accept && w_dec.corr && (r_corr_cnt != CNT_MAX)) begin
      r_corr_cnt <= r_corr_cnt + CNT_ONE;
    end else begin
      r_corr_cnt <= r_corr_cnt;
    end
  end

  // Double-error counter, same clear/saturation behaviour as above.
  always_ff @(posedge clk) begin
    if (reset || clr_cnt) begin
      r_derr_cnt <= CNT_ZERO;
    end else if (w_accept && w_dec.derr && (r_derr_cnt != CNT_MAX)) begin
      r_derr_cnt <= r_derr_cnt + CNT_ONE;
    end else begin
      r_derr_cnt <= r_derr_cnt;
    end
  end

  assign out_valid = r_out_valid;
  assign out_src   = r_out_src;
  assign out_data  = r_out_data;
  assign out_code  = r_out_code;
  assign out_corr  = r_out_corr;
  assign out_derr  = r_out_derr;
  assign corr_cnt  = r_corr_cnt;
  assign derr_cnt  = r_derr_cnt;

endmodule

// File: tb/tb_secded_decode_arbiter.sv
module tb_secded_decode_arbiter;

  localparam int CW = 2;

  logic          clk;
  logic          reset;
  logic [1:0]    in_valid;
  logic [7:0]    code0;
  logic [7:0]    code1;
  logic [15:0]   in_code;
  logic [1:0]    in_ready;
  logic          out_valid;
  logic          out_ready;
  logic          out_src;
  logic [3:0]    out_data;
  logic [7:0]    out_code;
  logic          out_corr;
  logic          out_derr;
  logic          clr_cnt;
  logic [CW-1:0] corr_cnt;
  logic [CW-1:0] derr_cnt;

  int checks   = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  assign in_code = {code1, code0};

  secded_decode_arbiter #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_code(in_code),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_src(out_src), .out_data(out_data), .out_code(out_code),
    .out_corr(out_corr), .out_derr(out_derr), .clr_cnt(clr_cnt),
    .corr_cnt(corr_cnt), .derr_cnt(derr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Build the valid codeword for a data nibble.
  function automatic logic [7:0] encode(input logic [3:0] d);
    logic [7:0] c;
    c    = 8'h00;
    c[2] = d[0];
    c[4] = d[1];
    c[5] = d[2];
    c[6] = d[3];
    c[0] = d[0] ^ d[1] ^ d[3];
    c[1] = d[0] ^ d[2] ^ d[3];
    c[3] = d[1] ^ d[2] ^ d[3];
    c[7] = ^c[6:0];
    return c;
  endfunction

  // Nearest-codeword decode: distance 0 clean, 1 corrected, else double error.
  // Result packing: {derr, corr, code[7:0], data[3:0]}.
  function automatic logic [13:0] model_decode(input logic [7:0] c);
    logic [13:0] r;
    logic [7:0]  cw;
    r = {1'b1, 1'b0, c, c[6], c[5], c[4], c[2]};
    for (int d = 0; d < 16; d++) begin
      cw = encode(d[3:0]);
      if ($countones(cw ^ c) == 0) r = {1'b0, 1'b0, c, d[3:0]};
      else if ($countones(cw ^ c) == 1) r = {1'b0, 1'b1, cw, d[3:0]};
    end
    return r;
  endfunction

  // Reference state.
  logic          m_valid, m_src, m_corr, m_derr, m_last;
  logic [3:0]    m_data;
  logic [7:0]    m_code;
  logic [CW-1:0] m_ccnt, m_dcnt;
  logic          m_gnt, m_acc;
  logic [1:0]    m_ready;
  logic [13:0]   m_dec;

  always_comb begin
    m_gnt = (in_valid == 2'b11) ? ~m_last : in_valid[1];
    m_acc = !reset && (in_valid != 2'b00) && (!m_valid || out_ready);
    m_ready = 2'b00;
    if (m_acc) m_ready = m_gnt ? 2'b10 : 2'b01;
    m_dec = model_decode(m_gnt ? code1 : code0);
  end

  always @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b0; m_src <= 1'b0; m_data <= 4'h0; m_code <= 8'h00;
      m_corr <= 1'b0; m_derr <= 1'b0; m_last <= 1'b1;
    end else if (m_acc) begin
      m_valid <= 1'b1; m_src <= m_gnt; m_last <= m_gnt;
      m_derr <= m_dec[13]; m_corr <= m_dec[12];
      m_code <= m_dec[11:4]; m_data <= m_dec[3:0];
    end else if (out_ready) begin
      m_valid <= 1'b0;
    end
    if (reset || clr_cnt) begin
      m_ccnt <= '0;
      m_dcnt <= '0;
    end else begin
      if (m_acc && m_dec[12] && m_ccnt < 2 ** CW - 1) m_ccnt <= m_ccnt + 1'b1;
      if (m_acc && m_dec[13] && m_dcnt < 2 ** CW - 1) m_dcnt <= m_dcnt + 1'b1;
    end
  end

  // Cycle-by-cycle comparison against the reference.
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", in_ready, m_ready);
      check("out_valid", out_valid, m_valid);
      check("out_src", out_src, m_src);
      check("out_data", out_data, m_data);
      check("out_code", out_code, m_code);
      check("out_corr", out_corr, m_corr);
      check("out_derr", out_derr, m_derr);
      check("corr_cnt", corr_cnt, m_ccnt);
      check("derr_cnt", derr_cnt, m_dcnt);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 2'b11; code0 = 8'h00; code1 = 8'h00;
    out_ready = 1'b1; clr_cnt = 1'b0;
    step();
    chk_en = 1'b1;
    check("rst_in_ready", in_ready, 2'b00);
    check("rst_valid", out_valid, 1'b0);
    check("rst_code", out_code, 8'h00);
    check("rst_cnt", {corr_cnt, derr_cnt}, 4'h0);
    in_valid = 2'b00;
    step();
    reset = 1'b0;

    // Clean word on port 0.
    in_valid = 2'b01; code0 = 8'h55;
    #1 check("clean_ready", in_ready, 2'b01);
    step();
    in_valid = 2'b00;
    check("clean_valid", out_valid, 1'b1);
    check("clean_src", out_src, 1'b0);
    check("clean_data", out_data, 4'b1011);
    check("clean_code", out_code, 8'h55);
    check("clean_flags", {out_corr, out_derr}, 2'b00);
    check("clean_cnt", corr_cnt, 2'd0);

    // Single data-bit error on port 1 (position 5).
    in_valid = 2'b10; code1 = 8'h45;
    step();
    check("s5_code", out_code, 8'h55);
    check("s5_src", out_src, 1'b1);
    check("s5_data", out_data, 4'b1011);
    check("s5_corr", out_corr, 1'b1);
    check("s5_cnt", corr_cnt, 2'd1);

    // Overall parity bit in error.
    code1 = 8'hD5;
    step();
    check("p7_code", out_code, 8'h55);
    check("p7_corr", out_corr, 1'b1);
    check("p7_cnt", corr_cnt, 2'd2);

    // Double error on port 0: raw codeword, data taken from raw bits.
    in_valid = 2'b01; code0 = 8'h56;
    step();
    in_valid = 2'b00;
    check("dbl_flags", {out_corr, out_derr}, 2'b01);
    check("dbl_code", out_code, 8'h56);
    check("dbl_data", out_data, 4'b1011);
    check("dbl_cnt", derr_cnt, 2'd1);

    // Reset while a result is held.
    out_ready = 1'b0;
    reset = 1'b1; in_valid = 2'b11;
    #1 check("mid_rst_ready", in_ready, 2'b00);
    step();
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_cnt", {corr_cnt, derr_cnt}, 4'h0);
    in_valid = 2'b00; out_ready = 1'b1;
    step();
    reset = 1'b0;

    // Round robin with both requesters always valid.
    in_valid = 2'b11; code0 = 8'h55; code1 = 8'h00;
    #1 check("rr_first_ready", in_ready, 2'b01);
    for (int i = 0; i < 4; i++) begin
      step();
      check("rr_valid", out_valid, 1'b1);
      check("rr_src", out_src, (i % 2 == 0) ? 1'b0 : 1'b1);
    end

    // Backpressure: held result stays put, nobody accepted.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check("bp_ready", in_ready, 2'b00);
      step();
      check("bp_src", out_src, 1'b1);
      check("bp_code", out_code, 8'h00);
      check("bp_valid", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    #1 check("bp_release_ready", in_ready, 2'b01);
    step();
    check("bp_release_src", out_src, 1'b0);
    check("bp_release_code", out_code, 8'h55);

    // Saturating corrected count.
    in_valid = 2'b01; code0 = 8'h54;
    for (int i = 0; i < 5; i++) step();
    check("sat_cnt", corr_cnt, 2'd3);
    check("sat_code", out_code, 8'h55);
    clr_cnt = 1'b1;
    step();
    check("clr_cnt", corr_cnt, 2'd0);
    check("clr_corr", out_corr, 1'b1);
    clr_cnt = 1'b0;
    step();
    check("post_clr_cnt", corr_cnt, 2'd1);

    // Drain-only cycle: valid drops, fields hold.
    in_valid = 2'b00;
    step();
    check("drain_valid", out_valid, 1'b0);
    check("drain_code", out_code, 8'h55);
    step();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
